// File: rtl/viterbi_traceback.sv
// Block-based traceback for an 8-state Viterbi decoder: stores DEPTH survivor
// vectors, walks them backwards from the best final state, then streams the decoded bits.
module viterbi_traceback #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] surv0,
    input  logic [2:0] surv1,
    input  logic [2:0] surv2,
    input  logic [2:0] surv3,
    input  logic [2:0] surv4,
    input  logic [2:0] surv5,
    input  logic [2:0] surv6,
    input  logic [2:0] surv7,
    input  logic [2:0] best_state,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic       out_last
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef enum logic [1:0] {FILL, TRACE, EMIT} state_t;

    state_t           state;
    state_t           state_next;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    out_ptr;
    logic [2:0]       cur_state;
    logic [2:0]       pred;
    logic [23:0]      row;
    logic [23:0]      mem [DEPTH];
    logic [DEPTH-1:0] bit_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_next;
    end

    // Outputs depend only on registered state and pointers, never on in_valid/out_ready.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_bit    = 1'b0;
        out_last   = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && wr_ptr == LAST) state_next = TRACE;
            end
            TRACE: begin
                if (rd_ptr == '0) state_next = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_bit   = bit_buf[out_ptr];
                out_last  = (out_ptr == LAST);
                if (out_ready && out_ptr == LAST) state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    // Survivor memory is never cleared; every row is rewritten before it is traced.
    always_ff @(posedge clk) begin
        if (state == FILL && in_valid)
            mem[wr_ptr] <= {surv7, surv6, surv5, surv4, surv3, surv2, surv1, surv0};
    end

    assign row = mem[rd_ptr];

    always_comb begin
        pred = row[2:0];
        case (cur_state)
            3'd0: pred = row[2:0];
            3'd1: pred = row[5:3];
            3'd2: pred = row[8:6];
            3'd3: pred = row[11:9];
            3'd4: pred = row[14:12];
            3'd5: pred = row[17:15];
            3'd6: pred = row[20:18];
            3'd7: pred = row[23:21];
            default: pred = row[2:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_ptr   <= '0;
            cur_state <= '0;
            bit_buf   <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        if (wr_ptr == LAST) begin
                            cur_state <= best_state;
                            rd_ptr    <= LAST;
                            wr_ptr    <= '0;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                TRACE: begin
                    // The MSB of the state is the input bit that entered at this step.
                    bit_buf[rd_ptr] <= cur_state[2];
                    cur_state       <= pred;
                    if (rd_ptr == '0) out_ptr <= '0;
                    else              rd_ptr  <= rd_ptr - 1'b1;
                end
                EMIT: begin
                    if (out_ready && out_ptr != LAST) out_ptr <= out_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback: a DEPTH=16 instance fed with encoder-consistent
// survivor paths plus a DEPTH=2 instance for the minimum-depth case.
module tb_viterbi_traceback;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] surv [8];
    logic [2:0] best_state = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_bit;
    logic       out_last;

    logic       d2_in_valid = 1'b0;
    logic       d2_in_ready;
    logic [2:0] d2_surv = '0;
    logic [2:0] d2_best = '0;
    logic       d2_out_valid;
    logic       d2_out_ready = 1'b0;
    logic       d2_out_bit;
    logic       d2_out_last;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    viterbi_traceback #(.DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .surv0(surv[0]), .surv1(surv[1]), .surv2(surv[2]), .surv3(surv[3]),
        .surv4(surv[4]), .surv5(surv[5]), .surv6(surv[6]), .surv7(surv[7]),
        .best_state(best_state), .out_valid(out_valid), .out_ready(out_ready),
        .out_bit(out_bit), .out_last(out_last)
    );

    viterbi_traceback #(.DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .surv0(d2_surv), .surv1(d2_surv), .surv2(d2_surv), .surv3(d2_surv),
        .surv4(d2_surv), .surv5(d2_surv), .surv6(d2_surv), .surv7(d2_surv),
        .best_state(d2_best), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .out_bit(d2_out_bit), .out_last(d2_out_last)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Encoder state after step t: {u_t, u_t-1, u_t-2}, with bits before step 0 taken as 0.
    function automatic logic [2:0] stateAt(input logic [15:0] u, input int t);
        logic [2:0] s;
        s = '0;
        for (int k = 0; k < 3; k++)
            if (t - k >= 0) s[2-k] = u[t-k];
        return s;
    endfunction

    task automatic applyStimulus(input logic [15:0] u, input bit diverge,
                                 input bit push, input bit hold_valid);
        for (int t = 0; t < 16; t++) begin
            in_valid = 1'b1;
            for (int j = 0; j < 8; j++) surv[j] = stateAt(u, t - 1);
            if (diverge && t == 15) begin
                for (int j = 0; j < 8; j++) surv[j] = 3'b111;
                surv[5] = 3'b010;
            end
            best_state = (t == 15) ? stateAt(u, 15) : 3'($urandom_range(7));
            @(negedge clk);
            checkVal("in_ready_fill", in_ready, 1'b1);
            @(posedge clk); #1;
            if (push) q.push_back('{b: u[t], last: (t == 15)});
        end
        in_valid = hold_valid;
        for (int j = 0; j < 8; j++) surv[j] = 3'($urandom_range(7));
        best_state = 3'($urandom_range(7));
    endtask

    task automatic waitTrace();
        int cnt;
        cnt = 0;
        while (cnt < 100) begin
            @(posedge clk);
            cnt++;
            #1;
            if (out_valid) break;
            checkVal("in_ready_trace", in_ready, 1'b0);
        end
        checkVal("trace_len", cnt, 16);
    endtask

    task automatic checkOutput(input logic [3:0] pattern);
        bit   done;
        bit   stalled;
        logic held_bit;
        logic held_last;
        exp_t e;
        done    = 0;
        stalled = 0;
        held_bit  = 1'b0;
        held_last = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            out_ready = pattern[i % 4];
            @(negedge clk);
            checkVal("in_ready_emit", in_ready, 1'b0);
            if (stalled) begin
                checkVal("hold_valid", out_valid, 1'b1);
                checkVal("hold_bit", out_bit, held_bit);
                checkVal("hold_last", out_last, held_last);
            end
            if (out_valid && out_ready) begin
                stalled = 0;
                if (q.size() == 0) begin
                    checkVal("extra_bit", 1'b1, 1'b0);
                    done = 1;
                end else begin
                    e = q.pop_front();
                    checkVal("out_bit", out_bit, e.b);
                    checkVal("out_last", out_last, e.last);
                    if (e.last) done = 1;
                end
            end else if (out_valid) begin
                stalled   = 1;
                held_bit  = out_bit;
                held_last = out_last;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkVal("emit_done", done, 1'b1);
        checkVal("queue_empty", q.size(), 0);
        checkVal("in_ready_return", in_ready, 1'b1);
        checkVal("out_valid_after", out_valid, 1'b0);
    endtask

    initial begin
        int cnt;
        for (int j = 0; j < 8; j++) surv[j] = '0;
        #1;
        checkVal("rst_in_ready", in_ready, 1'b1);
        checkVal("rst_out_valid", out_valid, 1'b0);
        checkVal("rst_out_bit", out_bit, 1'b0);
        checkVal("rst_out_last", out_last, 1'b0);
        checkVal("rst_d2_in_ready", d2_in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] zero trellis");
        applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0);
        waitTrace();
        checkOutput(4'b1111);

        $display("[TB] known path");
        applyStimulus(16'hC3A5, 1'b0, 1'b1, 1'b0);
        waitTrace();
        checkOutput(4'b1111);

        $display("[TB] divergent survivors");
        applyStimulus(16'hA000, 1'b1, 1'b1, 1'b0);
        waitTrace();
        checkOutput(4'b1111);

        $display("[TB] backpressure");
        applyStimulus(16'h6B1D, 1'b0, 1'b1, 1'b1);
        waitTrace();
        checkOutput(4'b1001);

        $display("[TB] reset mid-trace");
        applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkVal("midrst_in_ready", in_ready, 1'b1);
        checkVal("midrst_out_valid", out_valid, 1'b0);
        checkVal("midrst_out_bit", out_bit, 1'b0);
        checkVal("midrst_out_last", out_last, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(16'h5A3C, 1'b0, 1'b1, 1'b0);
        waitTrace();
        checkOutput(4'b1111);

        $display("[TB] depth 2");
        d2_in_valid = 1'b1;
        d2_surv     = 3'b000;
        d2_best     = 3'b001;
        @(negedge clk);
        checkVal("d2_in_ready_0", d2_in_ready, 1'b1);
        @(posedge clk); #1;
        d2_surv = 3'b100;
        d2_best = 3'b110;
        @(negedge clk);
        checkVal("d2_in_ready_1", d2_in_ready, 1'b1);
        @(posedge clk); #1;
        d2_in_valid = 1'b0;
        cnt = 0;
        while (cnt < 20) begin
            @(posedge clk);
            cnt++;
            #1;
            if (d2_out_valid) break;
        end
        checkVal("d2_trace_len", cnt, 2);
        d2_out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkVal("d2_out_valid", d2_out_valid, 1'b1);
            checkVal("d2_out_bit", d2_out_bit, 1'b1);
            checkVal("d2_out_last", d2_out_last, (k == 1));
            checkVal("d2_in_ready_emit", d2_in_ready, 1'b0);
            @(posedge clk); #1;
        end
        d2_out_ready = 1'b0;
        checkVal("d2_in_ready_return", d2_in_ready, 1'b1);
        checkVal("d2_out_valid_after", d2_out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
